wbu_commit: RTL
===============

Name: wbu_commit

Overview:
Parametrised write-back and commit stage. It sits between EXU and IFU and owns the architectural state: the GPR file, the machine CSRs (mstatus, mtvec, mepc, mcause, mscratch) and the PC. It accepts one retired instruction per valid/ready handshake, commits registers, CSRs and the next PC, then offers the next PC to IFU. Unlike the previous stage, it supports csrrc, mret and mscratch, has a configurable GPR count, flags unknown CSRs, and can accept back-to-back instructions.

Parameters:
XLEN, 32, datapath width
NREG, 32, GPR count (16 gives RV32E); RAW = $clog2(NREG)
RESET_PC, 32'h30000000, PC value after reset
MSTATUS_RST, 32'h1800, mstatus value after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  EXU has a retired instruction
in_ready  out  1  stage can accept
in_wen  in  1  GPR write enable
in_rd  in  RAW  destination GPR
in_wdata  in  XLEN  ALU/LSU result
in_rs1  in  XLEN  rs1 value (PC base and CSR source)
in_imm  in  XLEN  immediate
in_pca_sel  in  1  0: addend A = 4; 1: addend A = imm
in_pcb_sel  in  1  0: addend B = pc; 1: addend B = rs1
in_csr_op  in  3  000 none, 001 ecall, 010 csrrw, 011 csrrs, 100 mret, 101 csrrc
in_csr_addr  in  12  CSR number
out_valid  out  1  next PC available to IFU
out_ready  in  1  IFU accepts
out_pc  out  XLEN  current PC
raddr1, raddr2  in  RAW  decode read addresses
rdata1, rdata2  out  XLEN  combinational GPR reads; x0 reads 0
csr_err  out  1  one-cycle pulse on a CSR op to an unknown address

Behaviour:
- Reset (rst=0, async): out_pc=RESET_PC; out_valid=1 (first fetch); in_ready=0; all GPRs 0; mstatus=MSTATUS_RST; other CSRs 0; csr_err=0.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !out_valid | out_ready (combinational), so a commit and an IFU acceptance can occur in the same cycle.
- States: WAIT_IFU (out_valid=1) and WAIT_EXU (out_valid=0).
  - out_fire without in_fire -> WAIT_EXU.
  - in_fire -> WAIT_IFU. This holds even when out_fire fires in the same cycle; in that case out_valid stays 1.
- Commit on in_fire (single cycle; results visible in the next cycle):
  - Default next PC: A + B, modulo 2^XLEN, with A/B selected by in_pca_sel/in_pcb_sel.
  - GPR write: if in_wen and in_rd != 0, write in_wdata to in_rd.
  - ecall: mepc <= out_pc; mcause <= 11; PC <= mtvec. The GPR write is suppressed.
  - mret: PC <= mepc; mstatus.MIE <= MPIE; MPIE <= 1. No GPR write.
  - csrrw/csrrs/csrrc: old = CSR[in_csr_addr].
    - rd (if nonzero) <= old; this overrides in_wen/in_wdata.
    - New CSR value is in_rs1 (rw), old | in_rs1 (rs), or old & ~in_rs1 (rc).
    - Next PC is the default.
  - CSR addresses: 0x300 mstatus, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause.
  - Unknown CSR address: old reads 0, the CSR write is dropped, rd still gets 0, and csr_err pulses.
- No commit occurs without in_fire. out_pc, GPRs and CSRs hold.
- GPR reads are not bypassed. A value written in cycle N is visible on rdata from cycle N+1.
- Reset mid-transaction: all state returns to reset values immediately. The in-flight instruction is lost and no partial commit occurs.

Test Plan:
- Reset: hold rst=0, then release -> out_pc=0x30000000, out_valid=1, in_ready=0 until out_ready=1; mstatus reads 0x1800 via csrrs x5,0x300,x0.
- Back-to-back: out_ready=1 held, three in_fires with sel=00 and wen to x1/x2/x3 -> in_ready stays 1; PC steps 0x30000004, 0x30000008, 0x3000000C; rdata shows values one cycle later; a write to x0 still reads 0.
- jalr: rs1=0x80000010, sel=11, imm=8 -> out_pc=0x80000018; rd gets in_wdata.
- Trap round-trip: csrrw x0,mtvec with rs1=0x80001000; ecall at PC 0x30000020 -> out_pc=0x80001000, mepc=0x30000020, mcause=11; then mret -> out_pc=0x30000020.
- CSR ops: mscratch=0xF0F0, then csrrs with rs1=0x0F0F -> rd=0xF0F0 and mscratch=0xFFFF; then csrrc with rs1=0x00FF -> rd=0xFFFF and mscratch=0xFF00; csrrw to 0x7C0 -> csr_err pulses once, rd=0, and no CSR changes.
- Backpressure/reset: out_ready=0 with in_valid=1 -> in_ready=0 and no commit. Asserting rst mid-wait -> immediate reset values, and the held instruction is never committed.

Source files
------------

// File: rtl/wbu_commit.sv
// Write-back and commit stage: owns the GPR file, machine CSRs and the PC, retires one
// instruction per in handshake and offers the next PC to the fetch unit.
module wbu_commit #(
    parameter int                   XLEN        = 32,
    parameter int                   NREG        = 32,
    parameter logic [XLEN-1:0]      RESET_PC    = 32'h3000_0000,
    parameter logic [XLEN-1:0]      MSTATUS_RST = 32'h0000_1800,
    localparam int                  RAW         = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_wen,
    input  logic [RAW-1:0]  in_rd,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pca_sel,
    input  logic            in_pcb_sel,
    input  logic [2:0]      in_csr_op,
    input  logic [11:0]     in_csr_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    input  logic [RAW-1:0]  raddr1,
    input  logic [RAW-1:0]  raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            csr_err
);

    typedef enum logic { WAIT_IFU, WAIT_EXU } state_e;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_ECALL = 3'b001,
        OP_CSRRW = 3'b010,
        OP_CSRRS = 3'b011,
        OP_MRET  = 3'b100,
        OP_CSRRC = 3'b101
    } csr_op_e;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

    state_e          state, state_nxt;
    logic [XLEN-1:0] gpr [NREG];
    logic [XLEN-1:0] mstatus, mtvec, mepc, mcause, mscratch;

    logic            in_fire, out_fire;
    csr_op_e         op;
    logic            is_csr_rmw;
    logic            csr_known;
    logic [XLEN-1:0] csr_old, csr_new;
    logic [XLEN-1:0] pc_nxt;
    logic            gpr_we;
    logic [XLEN-1:0] gpr_wd;

    assign out_valid = (state == WAIT_IFU);
    assign in_ready  = !out_valid || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign op         = csr_op_e'(in_csr_op);
    assign is_csr_rmw = (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        state_nxt = state;
        if (in_fire)
            state_nxt = WAIT_IFU;
        else if (out_fire)
            state_nxt = WAIT_EXU;
    end

    always_comb begin
        csr_old   = '0;
        csr_known = 1'b1;
        case (in_csr_addr)
            ADDR_MSTATUS:  csr_old = mstatus;
            ADDR_MTVEC:    csr_old = mtvec;
            ADDR_MSCRATCH: csr_old = mscratch;
            ADDR_MEPC:     csr_old = mepc;
            ADDR_MCAUSE:   csr_old = mcause;
            default:       csr_known = 1'b0;
        endcase
    end

    always_comb begin
        csr_new = csr_old;
        case (op)
            OP_CSRRW: csr_new = in_rs1;
            OP_CSRRS: csr_new = csr_old | in_rs1;
            OP_CSRRC: csr_new = csr_old & ~in_rs1;
            default:  csr_new = csr_old;
        endcase
    end

    // Traps and returns override the adder; everything else uses A + B.
    always_comb begin
        pc_nxt = (in_pca_sel ? in_imm : XLEN'(4)) + (in_pcb_sel ? in_rs1 : out_pc);
        if (op == OP_ECALL)
            pc_nxt = mtvec;
        else if (op == OP_MRET)
            pc_nxt = mepc;
    end

    always_comb begin
        gpr_we = 1'b0;
        gpr_wd = in_wdata;
        if (is_csr_rmw) begin
            gpr_we = in_fire && (in_rd != '0);
            gpr_wd = csr_old;
        end else if (op != OP_ECALL && op != OP_MRET) begin
            gpr_we = in_fire && in_wen && (in_rd != '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= WAIT_IFU;
            out_pc   <= RESET_PC;
            mstatus  <= MSTATUS_RST;
            mtvec    <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mscratch <= '0;
            csr_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            csr_err <= in_fire && is_csr_rmw && !csr_known;
            if (in_fire) begin
                out_pc <= pc_nxt;
                case (op)
                    OP_ECALL: begin
                        mepc   <= out_pc;
                        mcause <= XLEN'(11);
                    end
                    OP_MRET: begin
                        mstatus[3] <= mstatus[7];
                        mstatus[7] <= 1'b1;
                    end
                    OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
                        case (in_csr_addr)
                            ADDR_MSTATUS:  mstatus  <= csr_new;
                            ADDR_MTVEC:    mtvec    <= csr_new;
                            ADDR_MSCRATCH: mscratch <= csr_new;
                            ADDR_MEPC:     mepc     <= csr_new;
                            ADDR_MCAUSE:   mcause   <= csr_new;
                            default:       ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the register file is reset explicitly because architectural GPRs must read 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++)
                gpr[i] <= '0;
        end else if (gpr_we) begin
            gpr[in_rd] <= gpr_wd;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : gpr[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : gpr[raddr2];

endmodule
